// File: rtl/seg_argmax.sv
// seg_argmax: pipelined per-pixel argmax over UNITS signed features, with VOID below THRESH.
// Optional per-frame class histogram is enabled by defining SEG_ARGMAX_HIST_EN.
// A histogram is only reported for a frame whose first active pixel was counted,
// so a reset in the middle of a frame never reports the partial counts.
module seg_argmax #(
    parameter int HEIGHT    = -1,
    parameter int WIDTH     = -1,
    parameter int W_HEIGHT  = -1,
    parameter int W_WIDTH   = -1,
    parameter int UNITS     = 12,
    parameter int INT_BITW  = 5,
    parameter int FRAC_BITW = 8,
    parameter int THRESH    = 0,
    localparam int FB = INT_BITW + FRAC_BITW,
    localparam int VB = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1,
    localparam int HB = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1,
    localparam int LB = $clog2(UNITS + 1),
    localparam int CB = (HEIGHT * WIDTH > 0) ? $clog2(HEIGHT * WIDTH + 1) : 1
) (
    input  logic                     clock,
    input  logic                     n_rst,
    input  logic                     in_enable,
    input  logic [0:FB*UNITS-1]      in_feat,
    input  logic [VB-1:0]            in_vcnt,
    input  logic [HB-1:0]            in_hcnt,
    output logic                     out_enable,
    output logic [LB-1:0]            out_label,
    output logic [FB-1:0]            out_score,
    output logic [VB-1:0]            out_vcnt,
    output logic [HB-1:0]            out_hcnt,
    output logic [(UNITS+1)*CB-1:0]  out_hist,
    output logic                     out_hist_vld
);
    localparam int D = (UNITS > 1) ? $clog2(UNITS) : 0;

    typedef logic signed [FB-1:0] feat_t;

    localparam feat_t TH = feat_t'(THRESH);

    // Level l of the tree holds width_at(l) live candidates; the upper half of
    // each level row is kept at zero so pair indexing never leaves the array.
    feat_t         val    [0:D][0:2*UNITS-1];
    logic [LB-1:0] idx    [0:D][0:2*UNITS-1];
    logic          en_d   [0:D];
    logic [VB-1:0] vcnt_d [0:D];
    logic [HB-1:0] hcnt_d [0:D];
    feat_t         best;

    function automatic int width_at(input int l);
        return (UNITS + (1 << l) - 1) >> l;
    endfunction

    assign best = val[D][0];

    // S0 captures the channels tagged with their index; S1..SD keep the larger of each pair, the left (lower index) on ties
    always_ff @(posedge clock) begin
        for (int k = 0; k < UNITS; k++) begin
            val[0][k] <= n_rst ? feat_t'(in_feat[FB*k +: FB]) : '0;
            idx[0][k] <= n_rst ? LB'(k) : '0;
        end
        for (int k = UNITS; k < 2*UNITS; k++) begin
            val[0][k] <= '0;
            idx[0][k] <= '0;
        end
        for (int l = 1; l <= D; l++) begin
            for (int j = 0; j < UNITS; j++) begin
                if (!n_rst || 2*j >= width_at(l-1)) begin
                    val[l][j] <= '0;
                    idx[l][j] <= '0;
                end else if (2*j+1 < width_at(l-1) && val[l-1][2*j+1] > val[l-1][2*j]) begin
                    val[l][j] <= val[l-1][2*j+1];
                    idx[l][j] <= idx[l-1][2*j+1];
                end else begin
                    val[l][j] <= val[l-1][2*j];
                    idx[l][j] <= idx[l-1][2*j];
                end
            end
            for (int j = UNITS; j < 2*UNITS; j++) begin
                val[l][j] <= '0;
                idx[l][j] <= '0;
            end
        end
    end

    // Enable and coordinates ride alongside the tree so they stay aligned with the data
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            for (int l = 0; l <= D; l++) begin
                en_d[l]   <= 1'b0;
                vcnt_d[l] <= '0;
                hcnt_d[l] <= '0;
            end
        end else begin
            en_d[0]   <= in_enable;
            vcnt_d[0] <= in_vcnt;
            hcnt_d[0] <= in_hcnt;
            for (int l = 1; l <= D; l++) begin
                en_d[l]   <= en_d[l-1];
                vcnt_d[l] <= vcnt_d[l-1];
                hcnt_d[l] <= hcnt_d[l-1];
            end
        end
    end

    // Final stage: VOID decision against the threshold and the output register
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            out_enable <= 1'b0;
            out_label  <= '0;
            out_score  <= '0;
            out_vcnt   <= '0;
            out_hcnt   <= '0;
        end else begin
            out_enable <= en_d[D];
            out_label  <= (best < TH) ? LB'(UNITS) : idx[D][0];
            out_score  <= best;
            out_vcnt   <= vcnt_d[D];
            out_hcnt   <= hcnt_d[D];
        end
    end

`ifdef SEG_ARGMAX_HIST_EN
    logic [CB-1:0] cnt [0:UNITS];
    logic          armed;
    logic          active;
    logic          frame_start;
    logic          frame_end;

    assign active      = out_enable && 32'(out_vcnt) < HEIGHT && 32'(out_hcnt) < WIDTH;
    assign frame_start = active && out_vcnt == '0 && out_hcnt == '0;
    assign frame_end   = active && 32'(out_vcnt) == HEIGHT - 1 && 32'(out_hcnt) == WIDTH - 1;

    // Per-class counters of active pixels; snapshot and clear at the last active pixel of a frame
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            armed        <= 1'b0;
            out_hist_vld <= 1'b0;
            out_hist     <= '0;
            for (int c = 0; c <= UNITS; c++) cnt[c] <= '0;
        end else begin
            armed        <= armed || frame_start;
            out_hist_vld <= frame_end && (armed || frame_start);
            for (int c = 0; c <= UNITS; c++) begin
                if (frame_end) begin
                    cnt[c] <= '0;
                    if (armed || frame_start)
                        out_hist[CB*c +: CB] <= cnt[c] + CB'(out_label == LB'(c));
                end else if (active && out_label == LB'(c)) begin
                    cnt[c] <= cnt[c] + CB'(1);
                end
            end
        end
    end
`else
    assign out_hist     = '0;
    assign out_hist_vld = 1'b0;
`endif

endmodule
